// File: rtl/wb_sram_pkg.sv
// Shared types and constants for the Wishbone-to-SRAM-macro bridge:
// FSM state encoding, CTRL register bit positions and CTRL address offset.
package wb_sram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   localparam int CTRL_LOCK = 0;
   localparam int CTRL_RUN  = 1;
   localparam int CTRL_VIOL = 2;

   localparam int WAIT_CNT_W = 2;

   // CTRL sits at the first byte past the SRAM window (4 bytes per word).
   function automatic logic [31:0] ctrl_offset(input int unsigned addr_w);
      return 32'd4 << addr_w;
   endfunction

endpackage

// File: rtl/wb_sram_bridge.sv
// Wishbone slave bridging to a single-port SRAM macro, plus a small CTRL
// register (write lock, core run release, sticky lock-violation flag).
module wb_sram_bridge
   import wb_sram_pkg::*;
#(
   parameter int          ADDR_W    = 9,
   parameter int          DATA_W    = 32,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          READ_LAT  = 1,
   localparam int         SEL_W     = DATA_W / 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [SEL_W-1:0]  wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [DATA_W-1:0] wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [DATA_W-1:0] wbs_dat_o,
   output logic              sram_csb,
   output logic              sram_web,
   output logic [SEL_W-1:0]  sram_wmask,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout,
   output logic              core_run_o
);

   localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(READ_LAT - 1);
   localparam logic [31:0]           CTRL_ADDR = BASE_ADDR + ctrl_offset(ADDR_W);

   state_t                  state_q, state_d;
   logic [WAIT_CNT_W-1:0]   wait_cnt_q;
   logic                    ack_en_q;
   logic                    op_we_q;
   logic                    lock_q, run_q, viol_q;
   logic [DATA_W-1:0]       dat_o_q;
   logic                    csb_q, web_q;
   logic [SEL_W-1:0]        wmask_q;
   logic [ADDR_W-1:0]       addr_q;
   logic [DATA_W-1:0]       din_q;

   logic                    accept;
   logic                    sram_hit, ctrl_hit;
   logic                    locked_wr;
   logic                    viol_set, viol_clr;
   logic [DATA_W-1:0]       ctrl_rd;

   assign accept    = (state_q == ST_IDLE) && wbs_cyc_i && wbs_stb_i;
   assign sram_hit  = (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
   assign ctrl_hit  = (wbs_adr_i == CTRL_ADDR);
   assign locked_wr = sram_hit && wbs_we_i && lock_q;
   assign viol_set  = accept && locked_wr;
   // Clearing viol is a plain write-one-to-clear, independent of byte select.
   assign viol_clr  = accept && ctrl_hit && wbs_we_i && wbs_dat_i[CTRL_VIOL];

   always_comb begin
      ctrl_rd            = '0;
      ctrl_rd[CTRL_LOCK] = lock_q;
      ctrl_rd[CTRL_RUN]  = run_q;
      ctrl_rd[CTRL_VIOL] = viol_q;
   end

   // FSM state register
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = sram_hit ? ST_ISSUE : ST_ACK;
         ST_ISSUE: state_d = op_we_q ? ST_ACK : ST_WAIT;
         ST_WAIT:  if (wait_cnt_q == LAST_WAIT) state_d = ST_ACK;
         ST_ACK:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      wbs_ack_o = 1'b0;
      if (state_q == ST_ACK && ack_en_q && wbs_cyc_i) wbs_ack_o = 1'b1;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wait_cnt_q <= '0;
         ack_en_q   <= 1'b0;
         op_we_q    <= 1'b0;
         lock_q     <= 1'b0;
         run_q      <= 1'b0;
         dat_o_q    <= '0;
         csb_q      <= 1'b1;
         web_q      <= 1'b1;
         wmask_q    <= '0;
         addr_q     <= '0;
         din_q      <= '0;
      end else begin
         if (accept) begin
            ack_en_q <= 1'b1;
            op_we_q  <= wbs_we_i;
            if (sram_hit) begin
               addr_q <= wbs_adr_i[ADDR_W+1:2];
               din_q  <= wbs_dat_i;
               if (!locked_wr) begin
                  csb_q   <= 1'b0;
                  web_q   <= ~wbs_we_i;
                  wmask_q <= wbs_we_i ? wbs_sel_i : '0;
               end
            end else if (ctrl_hit) begin
               if (wbs_we_i) begin
                  if (wbs_sel_i[0]) begin
                     lock_q <= wbs_dat_i[CTRL_LOCK];
                     run_q  <= wbs_dat_i[CTRL_RUN];
                  end
               end else begin
                  dat_o_q <= ctrl_rd;
               end
            end else if (!wbs_we_i) begin
               dat_o_q <= '0;
            end
         end else if (state_q != ST_IDLE && !wbs_cyc_i) begin
            // Master walked away: let the macro access finish, but never ack.
            ack_en_q <= 1'b0;
         end

         if (state_q == ST_ISSUE) begin
            csb_q      <= 1'b1;
            web_q      <= 1'b1;
            wmask_q    <= '0;
            wait_cnt_q <= '0;
         end

         if (state_q == ST_WAIT) begin
            if (wait_cnt_q == LAST_WAIT) begin
               if (ack_en_q && wbs_cyc_i) dat_o_q <= sram_dout;
            end else begin
               wait_cnt_q <= wait_cnt_q + 1'b1;
            end
         end
      end
   end

   // Sticky violation flag; a new violation outranks a simultaneous clear.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)      viol_q <= 1'b0;
      else if (viol_set) viol_q <= 1'b1;
      else if (viol_clr) viol_q <= 1'b0;
   end

   assign wbs_dat_o  = dat_o_q;
   assign sram_csb   = csb_q;
   assign sram_web   = web_q;
   assign sram_wmask = wmask_q;
   assign sram_addr  = addr_q;
   assign sram_din   = din_q;
   assign core_run_o = run_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Directed bench for wb_sram_bridge: two instances (read latency 1 and 3),
// each with a behavioural SRAM macro model.
module tb_wb_sram_bridge;

   localparam logic [31:0] CTRL_A = 32'h3000_0800;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc1 = 1'b0, stb1 = 1'b0, cyc3 = 1'b0, stb3 = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = 32'h0, dat = 32'h0;

   logic        ack1, csb1, web1, run1, ack3, csb3, web3, run3;
   logic [31:0] dato1, din1, dout1, dato3, din3, dout3;
   logic [3:0]  wmask1, wmask3;
   logic [8:0]  addr1, addr3;

   int checks = 0;
   int errors = 0;
   int lowcnt1 = 0, lowcnt3 = 0;
   logic        prev_ack1 = 1'b0, prev_ack3 = 1'b0;

   logic [8:0]  cap_addr;
   logic        cap_web;
   logic [3:0]  cap_wmask;
   logic [31:0] cap_din;

   always #5 clk = ~clk;

   wb_sram_bridge #(.READ_LAT(1)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc1), .wbs_stb_i(stb1),
      .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
      .wbs_ack_o(ack1), .wbs_dat_o(dato1), .sram_csb(csb1), .sram_web(web1),
      .sram_wmask(wmask1), .sram_addr(addr1), .sram_din(din1),
      .sram_dout(dout1), .core_run_o(run1));

   wb_sram_bridge #(.READ_LAT(3)) dut3 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc3), .wbs_stb_i(stb3),
      .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
      .wbs_ack_o(ack3), .wbs_dat_o(dato3), .sram_csb(csb3), .sram_web(web3),
      .sram_wmask(wmask3), .sram_addr(addr3), .sram_din(din3),
      .sram_dout(dout3), .core_run_o(run3));

   // SRAM macro models: data valid only once the configured latency has elapsed.
   logic [31:0] mem1 [512];
   logic [31:0] mem3 [512];
   logic [31:0] rq1 = 32'h0, rq3 = 32'h0;
   int          rc1 = 0, rc3 = 0;

   always @(posedge clk) begin
      if (!csb1) begin
         if (!web1) begin
            for (int b = 0; b < 4; b++)
               if (wmask1[b]) mem1[addr1][8*b +: 8] <= din1[8*b +: 8];
         end else begin
            rq1 <= mem1[addr1];
            rc1 <= 1;
         end
      end else if (rc1 > 1) rc1 <= rc1 - 1;
   end

   always @(posedge clk) begin
      if (!csb3) begin
         if (!web3) begin
            for (int b = 0; b < 4; b++)
               if (wmask3[b]) mem3[addr3][8*b +: 8] <= din3[8*b +: 8];
         end else begin
            rq3 <= mem3[addr3];
            rc3 <= 3;
         end
      end else if (rc3 > 1) rc3 <= rc3 - 1;
   end

   assign dout1 = (rc1 == 1) ? rq1 : 32'hBAD0_BAD0;
   assign dout3 = (rc3 == 1) ? rq3 : 32'hBAD0_BAD0;

   // Idle macro pins and ack spacing, every cycle out of reset.
   always @(negedge clk) begin
      if (!csb1) lowcnt1 = lowcnt1 + 1;
      if (!csb3) lowcnt3 = lowcnt3 + 1;
      if (!rst) begin
         checks = checks + 1;
         if ((csb1 && (web1 !== 1'b1 || wmask1 !== 4'h0)) ||
             (csb3 && (web3 !== 1'b1 || wmask3 !== 4'h0))) begin
            errors = errors + 1;
            $display("FAIL idle_pins: web1=%b wmask1=%h web3=%b wmask3=%h, need 1/0 while csb high",
                     web1, wmask1, web3, wmask3);
         end
         checks = checks + 1;
         if ((prev_ack1 && ack1) || (prev_ack3 && ack3)) begin
            errors = errors + 1;
            $display("FAIL ack_spacing: ack high two cycles in a row at %0t", $time);
         end
      end
      prev_ack1 = ack1;
      prev_ack3 = ack3;
   end

   // One Wishbone transfer; ack_cyc is the cycle of ack counted from accept (-1 = none).
   task automatic wb_access(input bit d3, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            output int ack_cyc, output logic [31:0] rd, output int lows);
      int l0;
      l0      = d3 ? lowcnt3 : lowcnt1;
      ack_cyc = -1;
      rd      = 32'h0;
      @(posedge clk); #1;
      we = w; adr = a; dat = d; sel = s;
      if (d3) begin cyc3 = 1'b1; stb3 = 1'b1; end
      else    begin cyc1 = 1'b1; stb1 = 1'b1; end
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (!d3 && !csb1) begin
            cap_addr = addr1; cap_web = web1; cap_wmask = wmask1; cap_din = din1;
         end
         if ((d3 ? ack3 : ack1) === 1'b1) begin
            ack_cyc = k;
            rd      = d3 ? dato3 : dato1;
            break;
         end
      end
      @(posedge clk); #1;
      cyc1 = 1'b0; stb1 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0; we = 1'b0;
      @(negedge clk);
      lows = (d3 ? lowcnt3 : lowcnt1) - l0;
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      checks++; if (ack1 !== 1'b0)     begin errors++; $display("FAIL rst_ack: got %b need 0", ack1); end
      checks++; if (dato1 !== 32'h0)   begin errors++; $display("FAIL rst_dat: got %h need 0", dato1); end
      checks++; if (csb1 !== 1'b1 || web1 !== 1'b1 || wmask1 !== 4'h0)
         begin errors++; $display("FAIL rst_macro: csb=%b web=%b wmask=%h need 1/1/0", csb1, web1, wmask1); end
      checks++; if (addr1 !== 9'h0 || din1 !== 32'h0)
         begin errors++; $display("FAIL rst_addr_din: addr=%h din=%h need 0/0", addr1, din1); end
      checks++; if (run1 !== 1'b0 || run3 !== 1'b0)
         begin errors++; $display("FAIL rst_run: got %b%b need 00", run1, run3); end
      rst = 1'b0;
   endtask

   task automatic test_write();
      int ac, lw; logic [31:0] rd;
      wb_access(0, 1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, ac, rd, lw);
      checks++; if (ac != 2) begin errors++; $display("FAIL wr_ack_cycle: got %0d need 2", ac); end
      checks++; if (lw != 1) begin errors++; $display("FAIL wr_csb_cycles: got %0d need 1", lw); end
      checks++; if (cap_addr !== 9'd4 || cap_web !== 1'b0 || cap_wmask !== 4'hF || cap_din !== 32'hDEAD_BEEF)
         begin errors++; $display("FAIL wr_pins: addr=%h web=%b wmask=%h din=%h need 004/0/f/deadbeef",
                                  cap_addr, cap_web, cap_wmask, cap_din); end
   endtask

   task automatic test_read();
      int ac, lw; logic [31:0] rd;
      wb_access(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF, ac, rd, lw);
      checks++; if (ac != 3) begin errors++; $display("FAIL rd1_ack_cycle: got %0d need 3", ac); end
      checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd1_data: got %h need deadbeef", rd); end
      repeat (3) @(negedge clk);
      checks++; if (dato1 !== 32'hDEAD_BEEF || ack1 !== 1'b0)
         begin errors++; $display("FAIL rd1_hold: dat=%h ack=%b need deadbeef/0", dato1, ack1); end
      wb_access(1, 1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, ac, rd, lw);
      checks++; if (ac != 2) begin errors++; $display("FAIL rd3_prewrite_ack: got %0d need 2", ac); end
      wb_access(1, 1'b0, 32'h3000_0010, 32'h0, 4'hF, ac, rd, lw);
      checks++; if (ac != 5) begin errors++; $display("FAIL rd3_ack_cycle: got %0d need 5", ac); end
      checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd3_data: got %h need deadbeef", rd); end
   endtask

   task automatic test_byte_mask();
      int ac, lw; logic [31:0] rd;
      wb_access(0, 1'b1, 32'h3000_0014, 32'hAAAA_AAAA, 4'hF, ac, rd, lw);
      wb_access(0, 1'b1, 32'h3000_0014, 32'h1122_3344, 4'b0101, ac, rd, lw);
      checks++; if (cap_wmask !== 4'b0101 || cap_addr !== 9'd5)
         begin errors++; $display("FAIL mask_pins: wmask=%h addr=%h need 5/005", cap_wmask, cap_addr); end
      wb_access(0, 1'b0, 32'h3000_0014, 32'h0, 4'hF, ac, rd, lw);
      checks++; if (rd !== 32'hAA22_AA44) begin errors++; $display("FAIL mask_data: got %h need aa22aa44", rd); end
      wb_access(0, 1'b1, 32'h3000_07FC, 32'h1234_5678, 4'hF, ac, rd, lw);
      checks++; if (cap_addr !== 9'h1FF) begin errors++; $display("FAIL top_word_addr: got %h need 1ff", cap_addr); end
      wb_access(0, 1'b0, 32'h3000_07FC, 32'h0, 4'hF, ac, rd, lw);
      checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL top_word_data: got %h need 12345678", rd); end
   endtask

   task automatic test_unmapped();
      int ac, lw; logic [31:0] rd;
      wb_access(0, 1'b0, 32'h3000_0900, 32'h0, 4'hF, ac, rd, lw);
      checks++; if (ac != 1 || rd !== 32'h0 || lw != 0)
         begin errors++; $display("FAIL unmapped_rd: ack=%0d dat=%h csb_low=%0d need 1/0/0", ac, rd, lw); end
      wb_access(0, 1'b1, 32'h2000_0010, 32'hFFFF_FFFF, 4'hF, ac, rd, lw);
      checks++; if (ac != 1 || lw != 0)
         begin errors++; $display("FAIL unmapped_wr: ack=%0d csb_low=%0d need 1/0", ac, lw); end
   endtask

   task automatic test_lock();
      int ac, lw; logic [31:0] rd;
      wb_access(0, 1'b1, CTRL_A, 32'h1, 4'hF, ac, rd, lw);
      checks++; if (ac != 1 || lw != 0) begin errors++; $display("FAIL ctrl_wr: ack=%0d csb_low=%0d need 1/0", ac, lw); end
      wb_access(0, 1'b1, 32'h3000_0020, 32'hCAFE_F00D, 4'hF, ac, rd, lw);
      checks++; if (ac != 2 || lw != 0) begin errors++; $display("FAIL locked_wr: ack=%0d csb_low=%0d need 2/0", ac, lw); end
      wb_access(0, 1'b0, CTRL_A, 32'h0, 4'hF, ac, rd, lw);
      checks++; if (ac != 1 || rd !== 32'h5) begin errors++; $display("FAIL ctrl_viol: ack=%0d dat=%h need 1/5", ac, rd); end
      wb_access(0, 1'b1, CTRL_A, 32'h4, 4'h0, ac, rd, lw);
      wb_access(0, 1'b0, CTRL_A, 32'h0, 4'hF, ac, rd, lw);
      checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ctrl_w1c: got %h need 1", rd); end
      wb_access(0, 1'b1, CTRL_A, 32'h0, 4'h1, ac, rd, lw);
      wb_access(0, 1'b1, 32'h3000_0020, 32'hCAFE_F00D, 4'hF, ac, rd, lw);
      checks++; if (lw != 1) begin errors++; $display("FAIL unlocked_wr: csb_low=%0d need 1", lw); end
      wb_access(0, 1'b0, CTRL_A, 32'h0, 4'hF, ac, rd, lw);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ctrl_clear: got %h need 0", rd); end
   endtask

   task automatic test_core_run();
      int ac, lw; logic [31:0] rd;
      checks++; if (run1 !== 1'b0) begin errors++; $display("FAIL run_pre: got %b need 0", run1); end
      wb_access(0, 1'b1, CTRL_A, 32'h2, 4'h1, ac, rd, lw);
      checks++; if (run1 !== 1'b1) begin errors++; $display("FAIL run_set: got %b need 1", run1); end
      wb_access(0, 1'b0, CTRL_A, 32'h0, 4'hF, ac, rd, lw);
      checks++; if (rd !== 32'h2) begin errors++; $display("FAIL run_readback: got %h need 2", rd); end
      @(negedge clk); rst = 1'b1; #1;
      checks++; if (run1 !== 1'b0) begin errors++; $display("FAIL run_async_rst: got %b need 0", run1); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_abort();
      int ac, lw, l0, acks; logic [31:0] rd;
      l0 = lowcnt1; acks = 0;
      @(posedge clk); #1;
      we = 1'b0; adr = 32'h3000_0014; cyc1 = 1'b1; stb1 = 1'b1;
      @(posedge clk); #1;
      cyc1 = 1'b0; stb1 = 1'b0;
      repeat (8) begin @(negedge clk); if (ack1) acks++; end
      checks++; if (acks != 0 || lowcnt1 - l0 != 1 || csb1 !== 1'b1)
         begin errors++; $display("FAIL cyc_drop: acks=%0d csb_low=%0d csb=%b need 0/1/1", acks, lowcnt1 - l0, csb1); end
      wb_access(0, 1'b0, 32'h3000_0014, 32'h0, 4'hF, ac, rd, lw);
      checks++; if (ac != 3 || rd !== 32'hAA22_AA44)
         begin errors++; $display("FAIL after_drop: ack=%0d dat=%h need 3/aa22aa44", ac, rd); end
      acks = 0;
      @(posedge clk); #1;
      adr = 32'h3000_07FC; cyc1 = 1'b1; stb1 = 1'b1;
      repeat (3) begin @(negedge clk); if (ack1) acks++; end
      rst = 1'b1; #1;
      checks++; if (acks != 0 || ack1 !== 1'b0 || csb1 !== 1'b1 || dato1 !== 32'h0)
         begin errors++; $display("FAIL rst_in_wait: acks=%0d ack=%b csb=%b dat=%h need 0/0/1/0", acks, ack1, csb1, dato1); end
      cyc1 = 1'b0; stb1 = 1'b0;
      @(negedge clk); rst = 1'b0;
      wb_access(0, 1'b0, 32'h3000_07FC, 32'h0, 4'hF, ac, rd, lw);
      checks++; if (ac != 3 || rd !== 32'h1234_5678)
         begin errors++; $display("FAIL after_rst: ack=%0d dat=%h need 3/12345678", ac, rd); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_byte_mask();
      test_unmapped();
      test_lock();
      test_core_run();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
